// File: rtl/twelve_bit_serial_subtractor.sv
// Digit-serial subtractor: diff = in1 - in2 - bin, one DIGIT-bit slice per clock,
// LSB slice first, with the borrow held in a flop between slices.
module twelve_bit_serial_subtractor #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DIGIT = 4,
  parameter int unsigned NDIG  = WIDTH / DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              borrow;
  logic [IDXW-1:0]   idx;
  logic [DIGIT-1:0]  a_dig;
  logic [DIGIT-1:0]  b_dig;
  logic [DIGIT:0]    sub;
  logic              last_digit;
  logic              accept;

  // Slice selection is a plain mux over digit positions.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx == IDXW'(i)) begin
        a_dig = a_reg[i*DIGIT +: DIGIT];
        b_dig = b_reg[i*DIGIT +: DIGIT];
      end
    end
    sub        = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow};
    last_digit = (idx == IDXW'(NDIG - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        a_reg  <= in1;
        b_reg  <= in2;
        borrow <= bin;
        idx    <= '0;
      end else if (state == CALC) begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (idx == IDXW'(i)) diff[i*DIGIT +: DIGIT] <= sub[DIGIT-1:0];
        end
        borrow <= sub[DIGIT];
        if (last_digit) begin
          idx  <= '0;
          bout <= sub[DIGIT];
          // The new result MSB is the top bit of the slice being written now.
          ovf  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                  (sub[DIGIT-1] != a_reg[WIDTH-1]);
        end else begin
          idx <= idx + IDXW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_twelve_bit_serial_subtractor.sv
// Self-checking bench for twelve_bit_serial_subtractor: directed vector table,
// handshake/reset corner sequences and random operands against an arithmetic model.
module tb_twelve_bit_serial_subtractor;

  localparam int unsigned WIDTH = 12;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int unsigned n_pass;
  int unsigned n_total;

  twelve_bit_serial_subtractor #(.WIDTH(12), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                       output logic [WIDTH-1:0] d, output logic bo, output logic ov);
    int ua, ub, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2048) ? ua - 4096 : ua;
    sb = (ub >= 2048) ? ub - 4096 : ub;
    sr = sa - sb - int'(bi);
    d  = WIDTH'((ua - ub - int'(bi)) & 32'hFFF);
    bo = (ua < ub + int'(bi));
    ov = (sr > 2047) || (sr < -2048);
  endtask

  // Accept one operation; returns with the accept edge just passed (+1 time unit).
  task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in1      = a;
    in2      = b;
    bin      = bi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1      = WIDTH'($urandom);
    in2      = WIDTH'($urandom);
    bin      = 1'($urandom);
  endtask

  // Counts edges after accept until out_valid; bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_total++;
      $display("FAIL wait_valid: out_valid never rose within 20 cycles");
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bi, input logic [WIDTH-1:0] ed, input logic ebo, input logic eov);
    int lat;
    out_ready = 1'b1;
    accept_op(a, b, bi);
    check({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    wait_valid(lat);
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_diff"}, 32'(diff), 32'(ed));
    check({name, "_bout"}, 32'(bout), 32'(ebo));
    check({name, "_ovf"}, 32'(ovf), 32'(eov));
    @(posedge clk);
    #1;
    check({name, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
    check({name, "_back_to_idle"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [WIDTH-1:0] md, hold_d;
    logic             mbo, mov, hold_bo, hold_ov;
    logic [WIDTH-1:0] ra, rb;
    logic             rbi;
    int               lat;

    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    bin       = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{a: 12'h123, b: 12'h045, bi: 1'b0, d: 12'h0DE, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 12'h000, b: 12'h001, bi: 1'b0, d: 12'hFFF, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 12'h800, b: 12'h001, bi: 1'b0, d: 12'h7FF, bo: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 12'h7FF, b: 12'hFFF, bi: 1'b0, d: 12'h800, bo: 1'b1, ov: 1'b1};
    vecs[4] = '{a: 12'h555, b: 12'h555, bi: 1'b1, d: 12'hFFF, bo: 1'b1, ov: 1'b0};
    vecs[5] = '{a: 12'h555, b: 12'h555, bi: 1'b0, d: 12'h000, bo: 1'b0, ov: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi,
             vecs[i].d, vecs[i].bo, vecs[i].ov);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    accept_op(12'h800, 12'h001, 1'b0);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd3);
    hold_d  = diff;
    hold_bo = bout;
    hold_ov = ovf;
    check("bp_diff", 32'(hold_d), 32'h7FF);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'($urandom);
      in1      = WIDTH'($urandom);
      in2      = WIDTH'($urandom);
      bin      = 1'($urandom);
      @(posedge clk);
      #1;
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_diff_held", 32'(diff), 32'h7FF);
      check("bp_bout_held", 32'(bout), 32'd0);
      check("bp_ovf_held", 32'(ovf), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_pop_valid", 32'(out_valid), 32'd0);
    check("bp_pop_idle", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_spurious", 32'(out_valid), 32'd0);

    // Reset after the first digit has been processed.
    accept_op(12'h123, 12'h045, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 12'h123, 12'h045, 1'b0, 12'h0DE, 1'b0, 1'b0);

    // Randomized operands, occasional consumer stalls.
    for (int n = 0; n < 40; n++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rbi = 1'($urandom);
      if (n % 8 == 0) ra = rb;
      model(ra, rb, rbi, md, mbo, mov);
      out_ready = 1'b0;
      accept_op(ra, rb, rbi);
      wait_valid(lat);
      check("rnd_latency", 32'(lat), 32'd3);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      check("rnd_diff", 32'(diff), 32'(md));
      check("rnd_bout", 32'(bout), 32'(mbo));
      check("rnd_ovf", 32'(ovf), 32'(mov));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rnd_pop", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
